// File: rtl/pll_conf_pkg.sv
// Shared state encoding and constants for the clock-synthesizer
// PLL configuration sequencer.
package pll_conf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_REG,
        ST_VAL,
        ST_GAP,
        ST_SETTLE,
        ST_FAIL
    } pll_state_e;

    localparam logic [6:0] PLL_I2C_ADDR = 7'h60;
    localparam int PLL_CONF_ENTRY_W = 16;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; stops at zero and flags it.
// Holds the PLL settle interval after the last register write.
module settle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pll_conf_sequencer.sv
// Walks a ROM profile of {reg, value} pairs and writes each pair to
// the external PLL over I2C, with retries and a post-load settle wait.
module pll_conf_sequencer
    import pll_conf_pkg::*;
#(
    parameter int         ENTRIES       = 63,
    parameter int         PROFILES      = 3,
    parameter int         BOOT_PROFILE  = 2,
    parameter logic [6:0] I2C_ADDR      = PLL_I2C_ADDR,
    parameter int         MAX_RETRIES   = 3,
    parameter int         SETTLE_CYCLES = 48_000
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        start,
    input  logic [1:0]                  profile,
    output logic                        busy,
    output logic                        pll_ready,
    output logic                        error,
    output logic [7:0]                  err_entry,
    output logic [7:0]                  rom_addr,
    input  logic [PLL_CONF_ENTRY_W-1:0] rom_data,
    output logic                        i2c_cmd_active,
    output logic [6:0]                  i2c_cmd_addr,
    output logic                        i2c_cmd_read,
    output logic                        i2c_data_valid,
    output logic [7:0]                  i2c_data_in,
    input  logic                        i2c_data_ready,
    input  logic                        i2c_addr_err,
    input  logic                        i2c_data_err
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [7:0]    ENT8      = 8'(ENTRIES);
    localparam logic [7:0]    LAST_IDX  = 8'(ENTRIES - 1);
    localparam logic [2:0]    NPROF     = 3'(PROFILES);
    localparam logic [1:0]    BOOT_P    = 2'(BOOT_PROFILE);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);

    pll_state_e    state, state_nxt;
    logic [1:0]    prof, prof_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [RW-1:0] retries, retries_nxt;
    logic          retry_pend, retry_pend_nxt;
    logic [7:0]    reg_byte, val_byte;

    logic       bus_err;
    logic       bus_nxt;
    logic [7:0] data_nxt;
    logic       clear_status, bad_prof, ready_set;
    logic       settle_load, settle_zero;

    assign bus_err = i2c_addr_err | i2c_data_err;

    always_comb begin
        state_nxt      = state;
        prof_nxt       = prof;
        idx_nxt        = idx;
        retries_nxt    = retries;
        retry_pend_nxt = retry_pend;
        clear_status   = 1'b0;
        bad_prof       = 1'b0;
        ready_set      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    clear_status = 1'b1;
                    if ({1'b0, profile} >= NPROF) begin
                        bad_prof = 1'b1;
                    end else begin
                        prof_nxt       = profile;
                        idx_nxt        = '0;
                        retries_nxt    = '0;
                        retry_pend_nxt = 1'b0;
                        state_nxt      = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_REG;
            ST_REG, ST_VAL: begin
                // A NACK wins over an accept seen in the same cycle
                if (bus_err) begin
                    retries_nxt = retries + 1'b1;
                    if (retries_nxt == RETRY_MAX) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        retry_pend_nxt = 1'b1;
                        state_nxt      = ST_GAP;
                    end
                end else if (i2c_data_ready) begin
                    state_nxt = (state == ST_REG) ? ST_VAL : ST_GAP;
                end
            end
            ST_GAP: begin
                if (retry_pend) begin
                    retry_pend_nxt = 1'b0;
                    state_nxt      = ST_FETCH;
                end else begin
                    retries_nxt = '0;
                    idx_nxt     = idx + 1'b1;
                    state_nxt   = (idx == LAST_IDX) ? ST_SETTLE : ST_FETCH;
                end
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    ready_set = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAIL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus_nxt = (state_nxt == ST_REG) || (state_nxt == ST_VAL);

    always_comb begin
        data_nxt = 8'h00;
        if (bus_nxt) begin
            if (state == ST_LOAD) begin
                data_nxt = rom_data[15:8];
            end else if (state_nxt == ST_VAL) begin
                data_nxt = val_byte;
            end else begin
                data_nxt = reg_byte;
            end
        end
    end

    // Reloaded on every GAP entry so the last accept starts the interval
    assign settle_load = (state_nxt == ST_GAP);

    settle_timer #(
        .W(SW)
    ) u_settle (
        .clk      (clk),
        .nreset   (nreset),
        .load     (settle_load),
        .load_val (SETTLE_LD),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= ST_FETCH;
            prof       <= BOOT_P;
            idx        <= '0;
            retries    <= '0;
            retry_pend <= 1'b0;
            reg_byte   <= '0;
            val_byte   <= '0;
        end else begin
            state      <= state_nxt;
            prof       <= prof_nxt;
            idx        <= idx_nxt;
            retries    <= retries_nxt;
            retry_pend <= retry_pend_nxt;
            if (state == ST_LOAD) begin
                reg_byte <= rom_data[15:8];
                val_byte <= rom_data[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            busy           <= 1'b0;
            pll_ready      <= 1'b0;
            error          <= 1'b0;
            err_entry      <= '0;
            rom_addr       <= '0;
            i2c_cmd_active <= 1'b0;
            i2c_data_valid <= 1'b0;
            i2c_data_in    <= '0;
        end else begin
            busy           <= (state != ST_IDLE);
            i2c_cmd_active <= bus_nxt;
            i2c_data_valid <= bus_nxt;
            i2c_data_in    <= data_nxt;
            if (state == ST_FETCH) begin
                rom_addr <= 8'(ENT8 * {6'd0, prof}) + idx;
            end
            if (clear_status) begin
                pll_ready <= 1'b0;
                error     <= 1'b0;
            end
            if (bad_prof) begin
                error     <= 1'b1;
                err_entry <= '0;
            end
            if (state == ST_FAIL) begin
                error     <= 1'b1;
                err_entry <= idx;
            end
            if (ready_set) begin
                pll_ready <= 1'b1;
            end
        end
    end

    assign i2c_cmd_addr = I2C_ADDR;
    assign i2c_cmd_read = 1'b0;

endmodule

// File: tb/tb_pll_conf_sequencer.sv
// Directed bench: async ROM model plus a small I2C slave model
// with programmable NACK injection.
module tb_pll_conf_sequencer;

    localparam int ENTRIES = 4;
    localparam int SETTLE  = 20;
    localparam int BYTE_T  = 3;
    localparam int BOUND   = 3000;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] profile = 2'd0;
    logic       busy, pll_ready, error;
    logic [7:0] err_entry, rom_addr;
    logic [15:0] rom_data;
    logic       i2c_cmd_active, i2c_cmd_read, i2c_data_valid;
    logic [6:0] i2c_cmd_addr;
    logic [7:0] i2c_data_in;
    logic       i2c_data_ready = 1'b0;
    logic       i2c_addr_err = 1'b0;
    logic       i2c_data_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pll_conf_sequencer #(
        .ENTRIES       (ENTRIES),
        .PROFILES      (3),
        .BOOT_PROFILE  (2),
        .I2C_ADDR      (7'h60),
        .MAX_RETRIES   (3),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .start          (start),
        .profile        (profile),
        .busy           (busy),
        .pll_ready      (pll_ready),
        .error          (error),
        .err_entry      (err_entry),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .i2c_cmd_active (i2c_cmd_active),
        .i2c_cmd_addr   (i2c_cmd_addr),
        .i2c_cmd_read   (i2c_cmd_read),
        .i2c_data_valid (i2c_data_valid),
        .i2c_data_in    (i2c_data_in),
        .i2c_data_ready (i2c_data_ready),
        .i2c_addr_err   (i2c_addr_err),
        .i2c_data_err   (i2c_data_err)
    );

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        logic [7:0] r, v;
        r = 8'h10 + a;
        v = 8'hA0 + a;
        return {r, v};
    endfunction

    assign rom_data = rom_word(rom_addr);

    int         cyc = 0;
    bit         in_txn = 0;
    bit         inj = 0;
    int         wait_cnt = 0;
    logic [7:0] err_target = 8'hFF;
    int         err_left = 0;
    bit         err_is_addr = 0;
    int         ready_edge = 0;
    int         rise_cyc = -1;
    logic       ready_d = 1'b0;
    logic [7:0] txn_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pll_ready && !ready_d) rise_cyc = cyc;
        ready_d = pll_ready;
    end

    always @(negedge clk) begin
        i2c_data_ready = 1'b0;
        if (!i2c_cmd_active) begin
            if (in_txn && inj && err_left > 0) err_left--;
            in_txn = 0;
            inj = 0;
            wait_cnt = 0;
            i2c_addr_err = 1'b0;
            i2c_data_err = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn = 1;
                txn_q.push_back(rom_addr);
                inj = (rom_addr == err_target) && (err_left != 0);
            end
            wait_cnt++;
            if (inj) begin
                if (wait_cnt == 2) begin
                    if (err_is_addr) i2c_addr_err = 1'b1;
                    else i2c_data_err = 1'b1;
                end
            end else if (i2c_data_valid && wait_cnt >= BYTE_T) begin
                i2c_data_ready = 1'b1;
                byte_q.push_back(i2c_data_in);
                ready_edge = cyc + 1;
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_txns(input string tag);
        check({tag, "_count"}, txn_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), txn_q[i], exp_q[i]);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pll_ready || error) && n < BOUND);
        #1;
        check({tag, "_timeout"}, 32'(n >= BOUND), 0);
    endtask

    task automatic pulse_start(input logic [1:0] p);
        @(negedge clk);
        start = 1'b1;
        profile = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n, gaps;
        logic [7:0] a;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", pll_ready, 0);
        check("rst_error", error, 0);
        check("rst_err_entry", err_entry, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_active", i2c_cmd_active, 0);
        check("rst_valid", i2c_data_valid, 0);
        check("rst_data", i2c_data_in, 0);
        check("rst_cmd_addr", i2c_cmd_addr, 7'h60);
        check("rst_cmd_read", i2c_cmd_read, 0);

        // boot run of profile 2
        txn_q.delete();
        byte_q.delete();
        nreset = 1'b1;
        wait_done("boot");
        check("boot_ready", pll_ready, 1);
        check("boot_error", error, 0);
        exp_q = '{8'd8, 8'd9, 8'd10, 8'd11};
        check_txns("boot");
        check("boot_bytes", byte_q.size(), 8);
        for (int i = 0; i < 4 && 2 * i + 1 < byte_q.size(); i++) begin
            a = 8'(8 + i);
            check($sformatf("boot_reg%0d", i), byte_q[2 * i], 8'h10 + a);
            check($sformatf("boot_val%0d", i), byte_q[2 * i + 1], 8'hA0 + a);
        end
        check("boot_settle", rise_cyc - ready_edge, SETTLE);
        repeat (2) @(negedge clk);
        check("boot_busy_end", busy, 0);

        // runtime switch to profile 1, ignored second start mid-run
        txn_q.delete();
        pulse_start(2'd1);
        check("rt_ready_clr", pll_ready, 0);
        check("rt_busy_n", busy, 0);
        @(negedge clk);
        check("rt_busy_n1", busy, 1);
        check("rt_addr_n1", rom_addr, 4);
        gaps = 0;
        n = 0;
        while (!pll_ready && n < BOUND) begin
            if (n == 10) begin
                start = 1'b1;
                profile = 2'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (!busy) gaps++;
        end
        start = 1'b0;
        #1;
        check("rt_timeout", 32'(n >= BOUND), 0);
        check("rt_busy_gaps", gaps, 0);
        check("rt_error", error, 0);
        exp_q = '{8'd4, 8'd5, 8'd6, 8'd7};
        check_txns("rt");
        repeat (3) @(negedge clk);

        // transient NACK on entry 2 of profile 1
        txn_q.delete();
        byte_q.delete();
        err_target = 8'd6;
        err_is_addr = 0;
        err_left = 2;
        pulse_start(2'd1);
        wait_done("tnack");
        check("tnack_error", error, 0);
        check("tnack_ready", pll_ready, 1);
        exp_q = '{8'd4, 8'd5, 8'd6, 8'd6, 8'd6, 8'd7};
        check_txns("tnack");
        check("tnack_bytes", byte_q.size(), 8);
        err_left = 0;
        repeat (3) @(negedge clk);

        // invalid profile
        txn_q.delete();
        pulse_start(2'd3);
        check("inv_error", error, 1);
        check("inv_err_entry", err_entry, 0);
        check("inv_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("inv_traffic", txn_q.size(), 0);
        check("inv_busy_late", busy, 0);

        // persistent address NACK on entry 1 of profile 0
        txn_q.delete();
        err_target = 8'd1;
        err_is_addr = 1;
        err_left = -1;
        pulse_start(2'd0);
        wait_done("pnack");
        check("pnack_error", error, 1);
        check("pnack_err_entry", err_entry, 1);
        check("pnack_ready", pll_ready, 0);
        exp_q = '{8'd0, 8'd1, 8'd1, 8'd1};
        repeat (20) @(negedge clk);
        check_txns("pnack");
        check("pnack_busy", busy, 0);
        err_left = 0;

        // reset during VAL of entry 1 (profile 1 -> addr 5)
        pulse_start(2'd1);
        n = 0;
        while (!(i2c_cmd_active && i2c_data_in == 8'hA5) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("mid_timeout", 32'(n >= BOUND), 0);
        nreset = 1'b0;
        @(negedge clk);
        check("mid_active", i2c_cmd_active, 0);
        check("mid_valid", i2c_data_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_error", error, 0);
        txn_q.delete();
        @(negedge clk);
        nreset = 1'b1;
        wait_done("mid");
        check("mid_ready", pll_ready, 1);
        exp_q = '{8'd8, 8'd9, 8'd10, 8'd11};
        check_txns("mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
